// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared state encoding, requester IDs and width defaults
package memory_port_arbiter_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE       = 2'd0;
   localparam state_t ST_DATA_BUSY  = 2'd1;
   localparam state_t ST_FETCH_BUSY = 2'd2;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/memory_port_arbiter_access_timer.sv
// rtl/memory_port_arbiter_access_timer.sv - loadable down-counter timing one memory access
module memory_port_arbiter_access_timer
   import memory_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic clk,
   input  logic resetN,
   input  logic load_i,
   output logic done_o
);
   localparam int CW = $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = LOAD_VAL;
      end else if (count_q != '0) begin
         count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Done on the edge where the count steps from 1 to 0.
   assign done_o = (count_q == ONE);

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one fixed-latency memory between fetch and data, drives stalls
module memory_port_arbiter
   import memory_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  ifReq,
   input  logic [ADDR_WIDTH-1:0] ifAddr,
   output logic                  ifReady,
   output logic [DATA_WIDTH-1:0] ifData,
   input  logic                  memReq,
   input  logic                  memWrite,
   input  logic [ADDR_WIDTH-1:0] memAddr,
   input  logic [DATA_WIDTH-1:0] memWriteData,
   output logic                  memReady,
   output logic [DATA_WIDTH-1:0] memReadData,
   output logic                  ramEnable,
   output logic                  ramWriteEnable,
   output logic [ADDR_WIDTH-1:0] ramAddr,
   output logic [DATA_WIDTH-1:0] ramWriteData,
   input  logic [DATA_WIDTH-1:0] ramReadData,
   output logic                  pcWrite,
   output logic                  ifIdWrite,
   output logic                  pipeHold
);
   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  if_ready_q, if_ready_d;
   logic                  mem_ready_q, mem_ready_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
   logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;

   logic if_elig, mem_elig, grant_valid, grant_data, timer_done, complete;

   // A requester whose ready is showing still has its req up from the finished access.
   assign if_elig  = ifReq  & ~if_ready_q;
   assign mem_elig = memReq & ~mem_ready_q;

   always_comb begin
      grant_valid = 1'b0;
      grant_data  = 1'b0;
      if (state_q == ST_IDLE) begin
         if (if_elig && mem_elig) begin
            grant_valid = 1'b1;
            grant_data  = (last_grant_q == REQ_FETCH);
         end else if (mem_elig) begin
            grant_valid = 1'b1;
            grant_data  = 1'b1;
         end else if (if_elig) begin
            grant_valid = 1'b1;
         end
      end
   end

   memory_port_arbiter_access_timer #(
      .MEM_LATENCY(MEM_LATENCY)
   ) u_timer (
      .clk   (clk),
      .resetN(resetN),
      .load_i(grant_valid),
      .done_o(timer_done)
   );

   assign complete = (state_q != ST_IDLE) & timer_done;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      if_ready_d   = 1'b0;
      mem_ready_d  = 1'b0;
      ram_en_d     = ram_en_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      if_data_d    = if_data_q;
      mem_rdata_d  = mem_rdata_q;
      if (grant_valid) begin
         state_d      = grant_data ? ST_DATA_BUSY : ST_FETCH_BUSY;
         last_grant_d = grant_data ? REQ_DATA : REQ_FETCH;
         ram_en_d     = 1'b1;
         ram_we_d     = grant_data & memWrite;
         ram_addr_d   = grant_data ? memAddr : ifAddr;
         if (grant_data) begin
            ram_wdata_d = memWriteData;
         end
      end
      if (complete) begin
         state_d  = ST_IDLE;
         ram_en_d = 1'b0;
         if (state_q == ST_FETCH_BUSY) begin
            if_ready_d = 1'b1;
            if_data_d  = ramReadData;
         end else begin
            mem_ready_d = 1'b1;
            // memWrite is held stable for the whole access, so it still marks a store here.
            if (!memWrite) begin
               mem_rdata_d = ramReadData;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ST_IDLE;
         last_grant_q <= REQ_FETCH;
         if_ready_q   <= 1'b0;
         mem_ready_q  <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         if_data_q    <= '0;
         mem_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         if_ready_q   <= if_ready_d;
         mem_ready_q  <= mem_ready_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         if_data_q    <= if_data_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

   assign ifReady        = if_ready_q;
   assign ifData         = if_data_q;
   assign memReady       = mem_ready_q;
   assign memReadData    = mem_rdata_q;
   assign ramEnable      = ram_en_q;
   assign ramWriteEnable = ram_we_q;
   assign ramAddr        = ram_addr_q;
   assign ramWriteData   = ram_wdata_q;

   assign pipeHold  = memReq & ~mem_ready_q;
   assign pcWrite   = ~(pipeHold | (ifReq & ~if_ready_q));
   assign ifIdWrite = pcWrite;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        resetN;
   logic        ifReq, memReq, memWrite;
   logic [31:0] ifAddr, memAddr, memWriteData;
   logic        ifReady, memReady, ramEnable, ramWriteEnable;
   logic [31:0] ifData, memReadData, ramAddr, ramWriteData, ramReadData;
   logic        pcWrite, ifIdWrite, pipeHold;

   logic        b_ifReq;
   logic [31:0] b_ifAddr;
   logic        b_ifReady, b_memReady, b_ramEnable, b_ramWriteEnable;
   logic [31:0] b_ifData, b_memReadData, b_ramAddr, b_ramWriteData, b_ramReadData;
   logic        b_pcWrite, b_ifIdWrite, b_pipeHold;

   always #5 clk = ~clk;

   memory_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .resetN(resetN),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifReady(ifReady), .ifData(ifData),
      .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWriteData(memWriteData),
      .memReady(memReady), .memReadData(memReadData),
      .ramEnable(ramEnable), .ramWriteEnable(ramWriteEnable), .ramAddr(ramAddr),
      .ramWriteData(ramWriteData), .ramReadData(ramReadData),
      .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .pipeHold(pipeHold)
   );

   memory_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .resetN(resetN),
      .ifReq(b_ifReq), .ifAddr(b_ifAddr), .ifReady(b_ifReady), .ifData(b_ifData),
      .memReq(1'b0), .memWrite(1'b0), .memAddr(32'h0), .memWriteData(32'h0),
      .memReady(b_memReady), .memReadData(b_memReadData),
      .ramEnable(b_ramEnable), .ramWriteEnable(b_ramWriteEnable), .ramAddr(b_ramAddr),
      .ramWriteData(b_ramWriteData), .ramReadData(b_ramReadData),
      .pcWrite(b_pcWrite), .ifIdWrite(b_ifIdWrite), .pipeHold(b_pipeHold)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h8C220004;
      return 32'hA5000000 | 32'(i);
   endfunction

   // Memory macro: read data only becomes valid LAT-1 cycles into the enable window.
   logic [31:0] ram [256];
   bit          ram_init;
   int          en_cnt;
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
         ram_init <= 1'b1;
      end else if (ramEnable && ramWriteEnable) begin
         ram[ramAddr[9:2]] <= ramWriteData;
      end
      en_cnt <= ramEnable ? en_cnt + 1 : 0;
   end
   assign ramReadData   = (ramEnable && en_cnt >= LAT - 1) ? ram[ramAddr[9:2]] : 32'h0BAD0BAD;
   assign b_ramReadData = b_ramEnable ? ram[b_ramAddr[9:2]] : 32'h0BAD0BAD;

   int total, bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Transaction model: an access granted in cycle g owns the memory in g+1..g+LAT
   // and reports ready in cycle g+LAT+1, where the next grant may already be made.
   int          cyc;
   bit          m_init, busy_m, own_data_m, wr_m, last_data_m;
   int          issue_m, ready_m;
   logic [31:0] addr_m, wdata_m, exp_ifdata, exp_memrdata;
   logic [31:0] mem_model [256];

   task automatic model_step();
      bit fire, e_ifr, e_memr, e_en, e_we, e_hold, e_pcw, if_el, mem_el, pick;
      if (!m_init) begin
         for (int i = 0; i < 256; i++) mem_model[i] = init_word(i);
         m_init = 1'b1;
      end
      cyc++;
      if (!resetN) begin
         busy_m = 1'b0; last_data_m = 1'b0;
         exp_ifdata = '0; exp_memrdata = '0;
         return;
      end
      fire   = busy_m && (ready_m == cyc);
      e_ifr  = fire && !own_data_m;
      e_memr = fire && own_data_m;
      if (fire) begin
         if (!own_data_m) exp_ifdata = mem_model[addr_m[9:2]];
         else if (wr_m) mem_model[addr_m[9:2]] = wdata_m;
         else exp_memrdata = mem_model[addr_m[9:2]];
      end
      e_en   = busy_m && (cyc > issue_m) && (cyc <= issue_m + LAT);
      e_we   = e_en && wr_m && (cyc == issue_m + 1);
      e_hold = memReq && !e_memr;
      e_pcw  = !(e_hold || (ifReq && !e_ifr));
      check("ifReady", ifReady, e_ifr);
      check("memReady", memReady, e_memr);
      check("ifData", ifData, exp_ifdata);
      check("memReadData", memReadData, exp_memrdata);
      check("ramEnable", ramEnable, e_en);
      check("ramWriteEnable", ramWriteEnable, e_we);
      check("pipeHold", pipeHold, e_hold);
      check("pcWrite", pcWrite, e_pcw);
      check("ifIdWrite", ifIdWrite, e_pcw);
      if (e_en) check("ramAddr", ramAddr, addr_m);
      if (e_we) check("ramWriteData", ramWriteData, wdata_m);
      if (fire) busy_m = 1'b0;
      if_el  = ifReq && !e_ifr;
      mem_el = memReq && !e_memr;
      if (!busy_m && (if_el || mem_el)) begin
         pick        = mem_el && (!if_el || !last_data_m);
         busy_m      = 1'b1;
         own_data_m  = pick;
         last_data_m = pick;
         issue_m     = cyc;
         ready_m     = cyc + LAT + 1;
         wr_m        = pick && memWrite;
         addr_m      = pick ? memAddr : ifAddr;
         wdata_m     = memWriteData;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   // which: 0 fetch, 1 data, 2 either, 3 fetch on the latency-1 instance
   task automatic wait_rdy(input int which, input string tag, output int n, output int we_n);
      n = 0; we_n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (ramWriteEnable) we_n++;
         if ((which == 0 && ifReady) || (which == 1 && memReady) ||
             (which == 2 && (ifReady || memReady)) || (which == 3 && b_ifReady)) return;
      end
      total++; bad++;
      $display("FAIL %s_timeout: got no ready after %0d cycles, required one", tag, n);
   endtask

   initial begin
      int   n, wen;
      byte  order [4];
      byte  exp_order [4];
      exp_order = '{8'h44, 8'h46, 8'h44, 8'h46};
      resetN = 1'b0; ifReq = 1'b0; memReq = 1'b0; memWrite = 1'b0;
      ifAddr = '0; memAddr = '0; memWriteData = '0; b_ifReq = 1'b0; b_ifAddr = '0;
      repeat (3) tick();
      check("rst_ifReady", ifReady, 0);
      check("rst_memReady", memReady, 0);
      check("rst_ramEnable", ramEnable, 0);
      check("rst_ifData", ifData, 0);
      check("rst_pcWrite", pcWrite, 1);
      resetN = 1'b1;
      tick();

      // single fetch
      ifReq = 1'b1; ifAddr = 32'h10;
      #1 check("t1_pcw_stall", pcWrite, 0);
      wait_rdy(0, "t1", n, wen);
      check("t1_latency", n, 3);
      check("t1_ifData", ifData, 32'h8C220004);
      ifReq = 1'b0;
      tick();

      // simultaneous requests: data first, then fetch
      ifReq = 1'b1; ifAddr = 32'h14; memReq = 1'b1; memWrite = 1'b0; memAddr = 32'h40;
      #1 check("t2_hold", pipeHold, 1);
      wait_rdy(1, "t2d", n, wen);
      check("t2_data_latency", n, 3);
      check("t2_memReadData", memReadData, 32'hA5000010);
      memReq = 1'b0;
      wait_rdy(0, "t2f", n, wen);
      check("t2_fetch_latency", n, 3);
      check("t2_ifData", ifData, 32'hA5000005);
      ifReq = 1'b0;
      tick();

      // both held: alternation with back-to-back grants
      ifReq = 1'b1; ifAddr = 32'h18; memReq = 1'b1; memAddr = 32'h44;
      for (int k = 0; k < 4; k++) begin
         wait_rdy(2, "t3", n, wen);
         order[k] = memReady ? 8'h44 : 8'h46;
         check($sformatf("t3_order%0d", k), order[k], exp_order[k]);
         check($sformatf("t3_gap%0d", k), n, 3);
      end
      ifReq = 1'b0; memReq = 1'b0;
      tick();

      // store, then load back
      memReq = 1'b1; memWrite = 1'b1; memAddr = 32'h80; memWriteData = 32'hFFFFFFFF;
      wait_rdy(1, "t4s", n, wen);
      check("t4_we_cycles", wen, 1);
      check("t4_store_latency", n, 3);
      check("t4_memReadData_kept", memReadData, 32'hA5000011);
      memReq = 1'b0; memWrite = 1'b0;
      tick();
      memReq = 1'b1; memAddr = 32'h80;
      wait_rdy(1, "t4l", n, wen);
      check("t4_loadback", memReadData, 32'hFFFFFFFF);
      memReq = 1'b0;
      tick();

      // reset in the middle of a fetch
      ifReq = 1'b1; ifAddr = 32'h20;
      tick();
      tick();
      #2 resetN = 1'b0;
      #1;
      check("t5_ifReady", ifReady, 0);
      check("t5_ramEnable", ramEnable, 0);
      check("t5_ramAddr", ramAddr, 0);
      check("t5_ifData", ifData, 0);
      check("t5_memReadData", memReadData, 0);
      tick();
      check("t5_no_ready", ifReady, 0);
      #1 resetN = 1'b1;
      wait_rdy(0, "t5", n, wen);
      check("t5_reissue_latency", n, 3);
      check("t5_ifData_after", ifData, 32'hA5000008);
      ifReq = 1'b0;
      tick();

      // latency-1 instance
      b_ifReq = 1'b1; b_ifAddr = 32'h10;
      wait_rdy(3, "t6", n, wen);
      check("t6_latency", n, 2);
      check("t6_ifData", b_ifData, 32'h8C220004);
      b_ifReq = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
